// File: rtl/retire_unit.sv
// In-order retire stage: selects the retirable head group, writes the register file
// and serialises stores via req/ack. Optional perf counters under RETIRE_PERF_EN.
package retire_unit_pkg;
    typedef struct packed {
        logic [4:0]  dest_reg;
        logic        dest_reg_valid;
        logic [31:0] result_lo;
    } rob_entry_t;
endpackage

module retire_unit
    import retire_unit_pkg::*;
#(
    parameter int EXT_COUNT    = 4,
    parameter int EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  rob_entry_t              slot_data     [EXT_COUNT],
    input  logic [EXT_COUNT-1:0]    slot_valid,
    input  logic [EXT_COUNT-1:0]    slot_kill,
    input  logic [EXT_COUNT-1:0]    slot_is_store,
    input  logic [31:0]             slot_st_addr  [EXT_COUNT],
    input  logic [31:0]             slot_st_data  [EXT_COUNT],
    input  logic [3:0]              slot_st_be    [EXT_COUNT],
    input  logic                    halt,
    output logic                    consume,
    output logic [EXTCOUNTLOG2-1:0] consume_count,
    output logic [EXT_COUNT-1:0]    rf_we,
    output logic [4:0]              rf_waddr      [EXT_COUNT],
    output logic [31:0]             rf_wdata      [EXT_COUNT],
    output logic                    st_req,
    output logic [31:0]             st_addr,
    output logic [31:0]             st_data,
    output logic [3:0]              st_be,
    input  logic                    st_ack,
    output logic [31:0]             perf_retired,
    output logic [31:0]             perf_killed
);

    typedef enum logic {RUN, ST_WAIT} state_t;

    state_t                 r_state;
    logic                   r_st_req;
    logic [31:0]            r_st_addr;
    logic [31:0]            r_st_data;
    logic [3:0]             r_st_be;

    logic [EXTCOUNTLOG2:0]  w_n;
    logic                   w_scan_stop;
    logic [EXT_COUNT-1:0]   w_in_group;
    logic [EXT_COUNT-1:0]   w_base_we;
    logic                   w_run;
    logic                   w_consume_run;
    logic                   w_store_start;

    assign w_run = (r_state == RUN);

    // Group ends at the first empty slot or the first live store; killed slots drain through.
    always_comb begin
        w_n         = '0;
        w_scan_stop = 1'b0;
        for (int i = 0; i < EXT_COUNT; i++) begin
            if (!w_scan_stop) begin
                if (!slot_valid[i] || (slot_is_store[i] && !slot_kill[i]))
                    w_scan_stop = 1'b1;
                else
                    w_n = (EXTCOUNTLOG2+1)'(i + 1);
            end
        end
    end

    always_comb begin
        w_in_group = '0;
        w_base_we  = '0;
        for (int i = 0; i < EXT_COUNT; i++) begin
            w_in_group[i] = ((EXTCOUNTLOG2+1)'(i) < w_n);
            w_base_we[i]  = w_in_group[i] & ~slot_kill[i] & slot_data[i].dest_reg_valid &
                            (slot_data[i].dest_reg != 5'd0) & ~halt & w_run & reset_n;
        end
    end

    // Youngest writer to a register wins inside one group.
    always_comb begin
        rf_we = w_base_we;
        for (int i = 0; i < EXT_COUNT; i++) begin
            for (int j = i + 1; j < EXT_COUNT; j++) begin
                if (w_base_we[j] && (slot_data[j].dest_reg == slot_data[i].dest_reg))
                    rf_we[i] = 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < EXT_COUNT; i++) begin
            rf_waddr[i] = slot_data[i].dest_reg;
            rf_wdata[i] = slot_data[i].result_lo;
        end
    end

    assign w_consume_run = (w_n != '0) & ~halt;
    assign w_store_start = w_run & slot_valid[0] & slot_is_store[0] & ~slot_kill[0] & ~halt;

    assign consume       = reset_n & (w_run ? w_consume_run : st_ack);
    assign consume_count = (w_run && w_consume_run) ? EXTCOUNTLOG2'(w_n - 1'b1) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= RUN;
            r_st_req  <= 1'b0;
            r_st_addr <= '0;
            r_st_data <= '0;
            r_st_be   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_store_start) begin
                        r_st_addr <= slot_st_addr[0];
                        r_st_data <= slot_st_data[0];
                        r_st_be   <= slot_st_be[0];
                        r_st_req  <= 1'b1;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (st_ack) begin
                        r_st_req <= 1'b0;
                        r_state  <= RUN;
                    end
                end
            endcase
        end
    end

    assign st_req  = r_st_req;
    assign st_addr = r_st_addr;
    assign st_data = r_st_data;
    assign st_be   = r_st_be;

`ifdef RETIRE_PERF_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_killed;
    logic [31:0] w_ret_inc;
    logic [31:0] w_kill_inc;

    always_comb begin
        w_ret_inc  = '0;
        w_kill_inc = '0;
        if (w_run && w_consume_run) begin
            for (int i = 0; i < EXT_COUNT; i++) begin
                if (w_in_group[i]) begin
                    if (slot_kill[i]) w_kill_inc = w_kill_inc + 32'd1;
                    else              w_ret_inc  = w_ret_inc + 32'd1;
                end
            end
        end else if (!w_run && st_ack) begin
            w_ret_inc = 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_retired <= '0;
            r_perf_killed  <= '0;
        end else begin
            r_perf_retired <= r_perf_retired + w_ret_inc;
            r_perf_killed  <= r_perf_killed + w_kill_inc;
        end
    end

    assign perf_retired = r_perf_retired;
    assign perf_killed  = r_perf_killed;
`else
    assign perf_retired = '0;
    assign perf_killed  = '0;
`endif

endmodule

// File: tb/tb_retire_unit.sv
// Bench for retire_unit: directed vector table, store/reset sequences, and
// randomized traffic checked against a queue-free behavioural model.
module tb_retire_unit;
    import retire_unit_pkg::*;

`ifdef RETIRE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    rob_entry_t  sd       [4];
    logic [3:0]  s_valid, s_kill, s_store;
    logic [31:0] s_addr   [4];
    logic [31:0] s_data   [4];
    logic [3:0]  s_be     [4];
    logic        halt, st_ack;
    logic        consume;
    logic [1:0]  consume_count;
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr [4];
    logic [31:0] rf_wdata [4];
    logic        st_req;
    logic [31:0] st_addr, st_data;
    logic [3:0]  st_be;
    logic [31:0] perf_retired, perf_killed;

    retire_unit #(.EXT_COUNT(4)) dut (
        .clock(clock), .reset_n(reset_n), .slot_data(sd), .slot_valid(s_valid),
        .slot_kill(s_kill), .slot_is_store(s_store), .slot_st_addr(s_addr),
        .slot_st_data(s_data), .slot_st_be(s_be), .halt(halt), .consume(consume),
        .consume_count(consume_count), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
        .st_be(st_be), .st_ack(st_ack), .perf_retired(perf_retired),
        .perf_killed(perf_killed)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: "a store is outstanding" plus its captured payload.
    bit          m_wait;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_be;
    logic [31:0] m_ret, m_kil;

    typedef struct packed {
        logic [3:0]  v, k, s, dv;
        logic [19:0] d;
        logic        h;
        logic        ec;
        logic [1:0]  cnt;
        logic [3:0]  we;
    } vec_t;

    vec_t tab [12];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 1'b0; m_addr = '0; m_data = '0; m_be = '0; m_ret = '0; m_kil = '0;
    endtask

    task automatic clear_slots();
        for (int i = 0; i < 4; i++) begin
            sd[i] = '0; s_addr[i] = '0; s_data[i] = '0; s_be[i] = '0;
        end
        s_valid = '0; s_kill = '0; s_store = '0; halt = 1'b0; st_ack = 1'b0;
    endtask

    task automatic set_slot(input int i, input bit v, input bit k, input bit s, input bit dv,
                            input logic [4:0] d, input logic [31:0] res, input logic [31:0] a);
        s_valid[i] = v; s_kill[i] = k; s_store[i] = s;
        sd[i].dest_reg = d; sd[i].dest_reg_valid = dv; sd[i].result_lo = res;
        s_addr[i] = a; s_data[i] = a ^ 32'h5A5A_5A5A; s_be[i] = a[3:0] | 4'h1;
    endtask

    // Compares outputs against the model at mid-cycle, then advances the model one edge.
    task automatic model_check();
        int n;
        bit en [4];
        int last [32];
        bit e_cons;
        int e_cnt;
        logic [3:0] e_we;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (!s_valid[i] || (s_store[i] && !s_kill[i])) break;
            n++;
        end
        e_we = '0;
        for (int i = 0; i < 4; i++) en[i] = 1'b0;
        if (!m_wait) begin
            e_cons = (n > 0) && !halt;
            e_cnt  = n - 1;
            for (int r = 0; r < 32; r++) last[r] = -1;
            for (int i = 0; i < n; i++) begin
                en[i] = !s_kill[i] && sd[i].dest_reg_valid && (sd[i].dest_reg != 0) && !halt;
                if (en[i]) last[sd[i].dest_reg] = i;
            end
            for (int i = 0; i < n; i++) e_we[i] = en[i] && (last[sd[i].dest_reg] == i);
        end else begin
            e_cons = st_ack;
            e_cnt  = 0;
        end
        check("consume", consume, e_cons);
        if (e_cons) check("consume_count", consume_count, e_cnt[1:0]);
        check("rf_we", rf_we, e_we);
        for (int i = 0; i < 4; i++) begin
            check("rf_waddr", rf_waddr[i], sd[i].dest_reg);
            check("rf_wdata", rf_wdata[i], sd[i].result_lo);
        end
        check("st_req", st_req, m_wait);
        check("st_addr", st_addr, m_addr);
        check("st_data", st_data, m_data);
        check("st_be", st_be, m_be);
        check("perf_retired", perf_retired, PERF ? m_ret : 32'd0);
        check("perf_killed", perf_killed, PERF ? m_kil : 32'd0);
        if (!m_wait) begin
            if (e_cons)
                for (int i = 0; i < n; i++)
                    if (s_kill[i]) m_kil++; else m_ret++;
            if (s_valid[0] && s_store[0] && !s_kill[0] && !halt) begin
                m_wait = 1'b1; m_addr = s_addr[0]; m_data = s_data[0]; m_be = s_be[0];
            end
        end else if (st_ack) begin
            m_wait = 1'b0;
            m_ret++;
        end
    endtask

    task automatic finish_cycle();
        model_check();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tab[0]  = '{v:4'hF, k:4'h0, s:4'h0, dv:4'hF, d:{5'd4,5'd3,5'd2,5'd1}, h:1'b0, ec:1'b1, cnt:2'd3, we:4'b1111};
        tab[1]  = '{v:4'h3, k:4'h0, s:4'h0, dv:4'hF, d:{5'd6,5'd6,5'd5,5'd5}, h:1'b0, ec:1'b1, cnt:2'd1, we:4'b0010};
        tab[2]  = '{v:4'hF, k:4'h3, s:4'h1, dv:4'hF, d:{5'd0,5'd8,5'd7,5'd0}, h:1'b0, ec:1'b1, cnt:2'd3, we:4'b0100};
        tab[3]  = '{v:4'hF, k:4'h0, s:4'h0, dv:4'hF, d:{5'd4,5'd3,5'd2,5'd1}, h:1'b1, ec:1'b0, cnt:2'd0, we:4'b0000};
        tab[4]  = '{v:4'hF, k:4'h0, s:4'h0, dv:4'hF, d:{5'd4,5'd3,5'd2,5'd1}, h:1'b0, ec:1'b1, cnt:2'd3, we:4'b1111};
        tab[5]  = '{v:4'h0, k:4'h0, s:4'h0, dv:4'hF, d:{5'd4,5'd3,5'd2,5'd1}, h:1'b0, ec:1'b0, cnt:2'd0, we:4'b0000};
        tab[6]  = '{v:4'h3, k:4'h0, s:4'h2, dv:4'h1, d:{5'd0,5'd0,5'd0,5'd2}, h:1'b0, ec:1'b1, cnt:2'd0, we:4'b0001};
        tab[7]  = '{v:4'hF, k:4'h0, s:4'h0, dv:4'hD, d:{5'd0,5'd3,5'd2,5'd1}, h:1'b0, ec:1'b1, cnt:2'd3, we:4'b0101};
        tab[8]  = '{v:4'hF, k:4'h0, s:4'h0, dv:4'hF, d:{5'd9,5'd9,5'd9,5'd9}, h:1'b0, ec:1'b1, cnt:2'd3, we:4'b1000};
        tab[9]  = '{v:4'hB, k:4'h2, s:4'h0, dv:4'hF, d:{5'd4,5'd3,5'd2,5'd1}, h:1'b0, ec:1'b1, cnt:2'd1, we:4'b0001};
        tab[10] = '{v:4'hF, k:4'h0, s:4'h4, dv:4'hF, d:{5'd4,5'd3,5'd2,5'd1}, h:1'b0, ec:1'b1, cnt:2'd1, we:4'b0011};
        tab[11] = '{v:4'h1, k:4'h0, s:4'h1, dv:4'hF, d:{5'd4,5'd3,5'd2,5'd1}, h:1'b1, ec:1'b0, cnt:2'd0, we:4'b0000};

        // Reset with four live ALU slots presented: nothing may retire or write.
        reset_n = 1'b0;
        clear_slots();
        for (int i = 0; i < 4; i++) set_slot(i, 1, 0, 0, 1, 5'(i + 1), 32'h1000 + i, 32'h0);
        model_reset();
        #12;
        check("reset consume", consume, 1'b0);
        check("reset rf_we", rf_we, 4'b0000);
        check("reset st_req", st_req, 1'b0);
        check("reset st_addr", st_addr, 32'h0);
        check("reset perf_retired", perf_retired, 32'h0);
        check("reset perf_killed", perf_killed, 32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        for (int t = 0; t < 12; t++) begin
            clear_slots();
            for (int i = 0; i < 4; i++)
                set_slot(i, tab[t].v[i], tab[t].k[i], tab[t].s[i], tab[t].dv[i],
                         tab[t].d[5*i +: 5], 32'hC0DE_0000 + 32'(t * 16 + i), 32'h0000_0040 + 32'(i * 4));
            halt = tab[t].h;
            #4;
            check($sformatf("tab%0d consume", t), consume, tab[t].ec);
            if (tab[t].ec) check($sformatf("tab%0d count", t), consume_count, tab[t].cnt);
            check($sformatf("tab%0d rf_we", t), rf_we, tab[t].we);
            for (int i = 0; i < 4; i++)
                if (tab[t].we[i])
                    check($sformatf("tab%0d wdata%0d", t, i), rf_wdata[i], 32'hC0DE_0000 + 32'(t * 16 + i));
            check($sformatf("tab%0d st_req", t), st_req, 1'b0);
            finish_cycle();
        end

        // ALU then store: the ALU retires alone, the store then goes out and waits for ack.
        clear_slots();
        set_slot(0, 1, 0, 0, 1, 5'd2, 32'hAAAA_0002, 32'h0);
        set_slot(1, 1, 0, 1, 0, 5'd0, 32'h0, 32'h0000_0100);
        #4;
        check("seq alu consume", consume, 1'b1);
        check("seq alu count", consume_count, 2'd0);
        check("seq alu rf_we", rf_we, 4'b0001);
        finish_cycle();
        clear_slots();
        set_slot(0, 1, 0, 1, 0, 5'd0, 32'h0, 32'h0000_0100);
        #4;
        check("seq st0 consume", consume, 1'b0);
        check("seq st0 st_req", st_req, 1'b0);
        finish_cycle();
        for (int c = 0; c < 3; c++) begin
            s_addr[0] = 32'h0000_0200 + 32'(c);
            halt = (c == 1);
            st_ack = (c == 2);
            #4;
            check("seq wait st_req", st_req, 1'b1);
            check("seq wait st_addr", st_addr, 32'h0000_0100);
            check("seq wait st_data", st_data, 32'h0000_0100 ^ 32'h5A5A_5A5A);
            check("seq wait rf_we", rf_we, 4'b0000);
            check("seq wait consume", consume, c == 2);
            if (c == 2) check("seq ack count", consume_count, 2'd0);
            finish_cycle();
        end
        clear_slots();
        #4;
        check("seq after ack st_req", st_req, 1'b0);
        finish_cycle();

        // Asynchronous reset while a store is outstanding.
        clear_slots();
        set_slot(0, 1, 0, 1, 0, 5'd0, 32'h0, 32'h0000_0300);
        finish_cycle();
        st_ack = 1'b0;
        #4;
        check("rst pre st_req", st_req, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst async st_req", st_req, 1'b0);
        check("rst async st_addr", st_addr, 32'h0);
        check("rst async consume", consume, 1'b0);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        clear_slots();
        set_slot(0, 1, 0, 1, 0, 5'd0, 32'h0, 32'h0000_0400);
        #4;
        check("rst fresh st_req0", st_req, 1'b0);
        finish_cycle();
        st_ack = 1'b1;
        #4;
        check("rst fresh st_req1", st_req, 1'b1);
        check("rst fresh st_addr", st_addr, 32'h0000_0400);
        check("rst fresh consume", consume, 1'b1);
        finish_cycle();
        clear_slots();
        #4;
        check("rst fresh drop", st_req, 1'b0);
        finish_cycle();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            clear_slots();
            for (int i = 0; i < 4; i++)
                set_slot(i, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20,
                         $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 80,
                         5'($urandom_range(0, 7)), $urandom, $urandom);
            halt   = $urandom_range(0, 99) < 10;
            st_ack = $urandom_range(0, 2) == 0;
            #4;
            finish_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
